// File: rtl/popcount_window_stats.sv
// Groups popcount samples into fixed windows of WIN samples and reports
// per-window sum, max, min and count of samples at or above THRESH.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | no samples held for the current window
// ACCUM | 1..WIN-1 samples of the current window are held
module popcount_window_stats #(
    parameter int CNT_W  = 6,
    parameter int WIN    = 8,
    parameter int SUM_W  = 9,
    parameter int THRESH = 16,
    parameter int HI_W   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cnt_valid,
    input  logic [CNT_W-1:0] count,
    input  logic             clear,
    output logic             busy,
    output logic             res_valid,
    output logic [SUM_W-1:0] res_sum,
    output logic [CNT_W-1:0] res_max,
    output logic [CNT_W-1:0] res_min,
    output logic [HI_W-1:0]  res_hi,
    output logic             range_err
);

    localparam int IDX_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(32);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [IDX_W-1:0] LEFT_INIT = IDX_W'(WIN - 1);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0] left;
    logic [SUM_W-1:0] acc_sum;
    logic [CNT_W-1:0] acc_max;
    logic [CNT_W-1:0] acc_min;
    logic [HI_W-1:0]  acc_hi;

    logic             accept;
    logic             over;
    logic             last;
    logic             first;
    logic             is_hi;
    logic [CNT_W-1:0] sample;
    logic [SUM_W-1:0] sum_nxt;
    logic [CNT_W-1:0] max_nxt;
    logic [CNT_W-1:0] min_nxt;
    logic [HI_W-1:0]  hi_nxt;

    // clear always wins over a coincident sample
    assign accept = cnt_valid & ~clear;
    assign over   = (count > CNT_MAX);
    assign sample = over ? CNT_MAX : count;
    assign is_hi  = (sample >= THRESH_C);
    assign first  = (state == IDLE);
    assign last   = accept && (left == '0);

    // The first sample of a window seeds every accumulator
    assign sum_nxt = (first ? '0 : acc_sum) + SUM_W'(sample);
    assign max_nxt = (first || (sample > acc_max)) ? sample : acc_max;
    assign min_nxt = (first || (sample < acc_min)) ? sample : acc_min;
    assign hi_nxt  = (first ? '0 : acc_hi) + HI_W'(is_hi);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !last) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                busy = 1'b1;
                if (clear || last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sample countdown reaches zero on the last sample of the window
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            left      <= LEFT_INIT;
            acc_sum   <= '0;
            acc_max   <= '0;
            acc_min   <= '0;
            acc_hi    <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_max   <= '0;
            res_min   <= '0;
            res_hi    <= '0;
            range_err <= 1'b0;
        end else begin
            res_valid <= last;
            if (accept && over) begin
                range_err <= 1'b1;
            end
            if (clear || last) begin
                left    <= LEFT_INIT;
                acc_sum <= '0;
                acc_max <= '0;
                acc_min <= '0;
                acc_hi  <= '0;
            end else if (accept) begin
                left    <= left - 1'b1;
                acc_sum <= sum_nxt;
                acc_max <= max_nxt;
                acc_min <= min_nxt;
                acc_hi  <= hi_nxt;
            end
            if (last) begin
                res_sum <= sum_nxt;
                res_max <= max_nxt;
                res_min <= min_nxt;
                res_hi  <= hi_nxt;
            end
        end
    end

endmodule

// File: tb/tb_popcount_window_stats.sv
// Directed bench for popcount_window_stats: hand-computed window results,
// gaps, back-to-back windows, clamping, clear and mid-window reset.
module tb_popcount_window_stats;

    logic       clk;
    logic       reset_n;
    logic       cnt_valid;
    logic [5:0] count;
    logic       clear;
    logic       busy;
    logic       res_valid;
    logic [8:0] res_sum;
    logic [5:0] res_max;
    logic [5:0] res_min;
    logic [3:0] res_hi;
    logic       range_err;

    int n_checks = 0;
    int n_fails  = 0;
    int pulses   = 0;
    int p0;

    popcount_window_stats #(
        .CNT_W(6), .WIN(8), .SUM_W(9), .THRESH(16), .HI_W(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cnt_valid(cnt_valid), .count(count),
        .clear(clear), .busy(busy), .res_valid(res_valid), .res_sum(res_sum),
        .res_max(res_max), .res_min(res_min), .res_hi(res_hi),
        .range_err(range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic v, input logic [5:0] c, input logic clr);
        cnt_valid = v;
        count     = c;
        clear     = clr;
        @(posedge clk);
        #1;
        if (res_valid) pulses++;
        cnt_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic check_res(input string tag, input int s, input int mx,
                             input int mn, input int hi);
        check({tag, "_valid"}, int'(res_valid), 1);
        check({tag, "_sum"}, int'(res_sum), s);
        check({tag, "_max"}, int'(res_max), mx);
        check({tag, "_min"}, int'(res_min), mn);
        check({tag, "_hi"}, int'(res_hi), hi);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_valid"}, int'(res_valid), 0);
        check({tag, "_sum"}, int'(res_sum), 0);
        check({tag, "_max"}, int'(res_max), 0);
        check({tag, "_min"}, int'(res_min), 0);
        check({tag, "_hi"}, int'(res_hi), 0);
        check({tag, "_rerr"}, int'(range_err), 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        cnt_valid = 1'b0;
        count     = '0;
        clear     = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        check_zero("reset");
        reset_n = 1'b1;

        // Window 1: mixed values
        step(1, 20, 0);
        check("w1_busy_first", int'(busy), 1);
        step(1, 19, 0);
        step(1, 17, 0);
        step(1, 2, 0);
        step(1, 8, 0);
        step(1, 5, 0);
        step(1, 11, 0);
        check("w1_no_early_valid", int'(res_valid), 0);
        step(1, 16, 0);
        check_res("w1", 98, 20, 2, 4);
        check("w1_busy_done", int'(busy), 0);
        step(0, 0, 0);
        check("w1_pulse_one_cycle", int'(res_valid), 0);
        check("w1_hold_sum", int'(res_sum), 98);

        // Window 2: all 32 with a gap after every sample
        p0 = pulses;
        for (int i = 0; i < 7; i++) begin
            step(1, 32, 0);
            step(0, 0, 0);
        end
        step(1, 32, 0);
        check_res("w2", 256, 32, 32, 8);
        check("w2_pulses", pulses - p0, 1);

        // Windows 3 and 4 back to back
        for (int i = 0; i < 8; i++) step(1, 10, 0);
        check_res("w3", 80, 10, 10, 0);
        p0 = pulses;
        step(1, 0, 0);
        check("w4_first_busy", int'(busy), 1);
        check("w4_first_hold", int'(res_sum), 80);
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        check_res("w4", 0, 0, 0, 0);
        check("w4_pulses", pulses - p0, 1);

        // Window 5: out-of-range sample is clamped
        check("w5_rerr_before", int'(range_err), 0);
        step(1, 45, 0);
        check("w5_rerr_set", int'(range_err), 1);
        for (int i = 0; i < 7; i++) step(1, 1, 0);
        check_res("w5", 39, 32, 1, 1);
        check("w5_rerr_sticky", int'(range_err), 1);

        // Window 6: aborted by clear, including clear with a valid sample
        p0 = pulses;
        step(1, 30, 0);
        step(1, 30, 0);
        step(1, 30, 0);
        step(1, 30, 1);
        check("w6_clear_busy", int'(busy), 0);
        check("w6_clear_hold_sum", int'(res_sum), 39);
        for (int i = 0; i < 7; i++) step(1, 1, 0);
        check("w6_no_early_valid", int'(res_valid), 0);
        check("w6_hold_max", int'(res_max), 32);
        step(1, 1, 0);
        check_res("w7", 8, 1, 1, 0);
        check("w7_pulses", pulses - p0, 1);

        // Reset in the middle of a window
        p0 = pulses;
        for (int i = 0; i < 5; i++) step(1, 3, 0);
        reset_n = 1'b0;
        step(0, 0, 0);
        check_zero("midrst");
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1, 3, 0);
        check_res("w8", 24, 3, 3, 0);
        check("w8_pulses", pulses - p0, 1);
        step(0, 0, 0);
        check("w8_end_valid", int'(res_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
